char_sequencer: RTL and testbench

CHAR_SEQUENCER -- requirements
Module: char_sequencer

---
 rtl/char_sequencer.sv | 139 +++++++++++++
 tb/tb_char_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_sequencer.sv
// char_sequencer: stores up to DEPTH 7-bit character codes and replays them, one strobe per GAP_TICKS ticks.
// Build option: define CHAR_SEQ_LOOP_EN to wrap playback to the first character until aborted.
module char_sequencer #(
  parameter int DEPTH     = 16,
  parameter int GAP_TICKS = 30
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     tick,
  input  logic                     wr_en,
  input  logic [6:0]               wr_data,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     abort,
  output logic [6:0]               char_out,
  output logic                     char_available,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  // state | meaning
  // IDLE  | accepts writes and clear, waits for start
  // EMIT  | one-clk strobe of the character at rd_ptr
  // WAIT  | counts ticks until the next strobe or end of message
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ZERO = '0;
  localparam logic [7:0]  GAP_LOAD = 8'(GAP_TICKS);

  logic [6:0]  mem_q [DEPTH];
  logic [1:0]  state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  gap_q, gap_d;
  logic        overflow_q, overflow_d;
  logic        done_q, done_d;
  logic [6:0]  char_q, char_d;
  logic        mem_we;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    gap_d      = gap_q;
    overflow_d = overflow_q;
    char_d     = char_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clear) begin
          count_d    = PTR_ZERO;
          overflow_d = 1'b0;
        end else if (wr_en) begin
          if (count_q < DEPTH_C) begin
            mem_we  = 1'b1;
            count_d = count_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end else if (start && (count_q != PTR_ZERO)) begin
          state_d  = S_EMIT;
          rd_ptr_d = PTR_ZERO;
          char_d   = mem_q[0];
        end
      end
      S_EMIT: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        gap_d    = GAP_LOAD;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (tick) begin
          if (gap_q == 8'd1) begin
            if (rd_ptr_q < count_q) begin
              state_d = S_EMIT;
              char_d  = mem_q[rd_ptr_q[AW-1:0]];
            end else begin
`ifdef CHAR_SEQ_LOOP_EN
              state_d  = S_EMIT;
              rd_ptr_d = PTR_ZERO;
              char_d   = mem_q[0];
`else
              state_d = S_IDLE;
              done_d  = 1'b1;
`endif
            end
          end else begin
            gap_d = gap_q - 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // abort overrides everything above, including a pending start or end-of-message
    if (abort) begin
      state_d  = S_IDLE;
      rd_ptr_d = PTR_ZERO;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      gap_q      <= 8'd0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      char_q     <= 7'h00;
    end else if (ena) begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      gap_q      <= gap_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      char_q     <= char_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && ena && mem_we) mem_q[count_q[AW-1:0]] <= wr_data;
  end

  // A strobe or done held while ena is low re-appears once ena returns.
  assign char_available = ena && (state_q == S_EMIT);
  assign done           = ena && done_q;
  assign busy           = (state_q != S_IDLE);
  assign char_out       = char_q;
  assign count          = count_q;
  assign overflow       = overflow_q;
endmodule

// File: tb/tb_char_sequencer.sv
// Scoreboard bench for char_sequencer: expected strobes/done are derived from a tick-schedule model.
module tb_char_sequencer;
  localparam int DEPTH    = 16;
  localparam int GAP      = 3;
  localparam int PLAN_MAX = 512;

  logic       clk, rst_n, ena, tick, wr_en, clear, start, abort;
  logic [6:0] wr_data, char_out;
  logic       char_available, busy, done, overflow;
  logic [4:0] count;

  char_sequencer #(.DEPTH(DEPTH), .GAP_TICKS(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick), .wr_en(wr_en), .wr_data(wr_data),
    .clear(clear), .start(start), .abort(abort), .char_out(char_out),
    .char_available(char_available), .busy(busy), .done(done), .count(count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int cyc; logic [6:0] ch; } ev_t;
  ev_t sq[$];
  int  dq[$];

  int n_chk = 0;
  int n_pass = 0;

  logic [6:0] ref_mem [DEPTH];
  int ref_count = 0;
  int ref_ovf = 0;
  bit pl_tick [PLAN_MAX];
  bit pl_ena  [PLAN_MAX];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes or signals done.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && char_available === 1'b1) begin
      if (sq.size() == 0) chk("unexpected_strobe", 1, 0);
      else begin
        e = sq.pop_front();
        chk("strobe_char", int'(char_out), int'(e.ch));
        chk("strobe_cycle", cyc, e.cyc);
      end
    end
    if (rst_n && done === 1'b1) begin
      if (dq.size() == 0) chk("unexpected_done", 1, 0);
      else chk("done_cycle", cyc, dq.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [6:0] d);
    wr_en = 1'b1; wr_data = d;
    step();
    wr_en = 1'b0;
    if (ref_count < DEPTH) begin ref_mem[ref_count] = d; ref_count++; end
    else ref_ovf = 1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    ref_count = 0; ref_ovf = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_count"}, int'(count), ref_count);
    chk({tag, "_overflow"}, int'(overflow), ref_ovf);
  endtask

  task automatic plan_random(input int stop);
    for (int r = 0; r <= stop; r++) begin
      pl_tick[r] = ($urandom_range(0, 2) == 0);
      pl_ena[r]  = ($urandom_range(0, 9) != 0);
    end
    pl_ena[0] = 1'b1; pl_ena[stop] = 1'b1;
  endtask

  // Reference: strobe k+1 falls on the first enabled clk after the GAP-th enabled tick
  // that comes strictly after strobe k. Everything after the abort cycle 'stop' is discarded.
  task automatic predict(input int base, input int stop, output int end_rel);
    int c, t, seen, idx;
    end_rel = stop + 1;
    idx = 0;
    c = 1;
    while (c <= stop && !pl_ena[c]) c++;
    forever begin
      if (c > stop) return;
      sq.push_back('{base + c, ref_mem[idx]});
      idx++;
      seen = 0; t = c;
      while (seen < GAP) begin
        t++;
        if (t > stop) return;
        if (pl_tick[t] && pl_ena[t]) seen++;
      end
      if (t >= stop) return;
      c = t + 1;
      while (c <= stop && !pl_ena[c]) c++;
      if (idx == ref_count) begin
`ifdef CHAR_SEQ_LOOP_EN
        idx = 0;
`else
        end_rel = t + 1;
        dq.push_back(base + c);
        return;
`endif
      end
    end
  endtask

  // Start at rel 0, abort at rel 'stop'; ignored-input noise only while the DUT is busy.
  task automatic play(input int stop, input bit noise, input bit use_model, input int end_in);
    int base, end_rel;
    base = cyc;
    end_rel = end_in;
    if (use_model) predict(base, stop, end_rel);
    for (int r = 0; r <= stop; r++) begin
      chk("busy", int'(busy), (r >= 1 && r < end_rel) ? 1 : 0);
      tick = pl_tick[r]; ena = pl_ena[r];
      start = (r == 0); abort = (r == stop);
      wr_en = 1'b0; clear = 1'b0; wr_data = 7'($urandom_range(0, 127));
      if (noise && r >= 1 && r < end_rel) begin
        wr_en = ($urandom_range(0, 3) == 0);
        clear = ($urandom_range(0, 7) == 0);
        start = ($urandom_range(0, 3) == 0);
      end
      step();
    end
    tick = 0; ena = 1; start = 0; abort = 0; wr_en = 0; clear = 0;
    chk("busy_after_play", int'(busy), 0);
  endtask

  task automatic plan_fill(input int stop, input int tick_period);
    for (int r = 0; r <= stop; r++) begin
      pl_tick[r] = (r > 0) && (r % tick_period == 0);
      pl_ena[r]  = 1'b1;
    end
  endtask

  initial begin
    int base, len;
    rst_n = 0; ena = 1; tick = 0; wr_en = 0; wr_data = 0; clear = 0; start = 0; abort = 0;
    step(); step();
    rst_n = 1;
    chk("rst_char_out", int'(char_out), 0);
    chk("rst_char_available", int'(char_available), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_overflow", int'(overflow), 0);

`ifndef CHAR_SEQ_LOOP_EN
    // 'H','I' with a tick every 4 clk: strobes at rel 1 and 13, done at rel 25.
    do_write(7'h48); do_write(7'h49);
    chk("hi_count", int'(count), 2);
    plan_fill(30, 4);
    base = cyc;
    sq.push_back('{base + 1, 7'h48});
    sq.push_back('{base + 13, 7'h49});
    dq.push_back(base + 25);
    play(30, 1'b0, 1'b0, 25);
    chk("hi_count_after", int'(count), 2);
`endif

    // Overflow and clear.
    do_clear();
    for (int i = 0; i < 17; i++) do_write(7'(8'h30 + i));
    chk("ovf_count", int'(count), 16);
    chk("ovf_flag", int'(overflow), 1);
    do_clear();
    chk("clr_count", int'(count), 0);
    chk("clr_overflow", int'(overflow), 0);

    // Clear beats a simultaneous write.
    wr_en = 1; clear = 1; wr_data = 7'h11;
    step();
    wr_en = 0; clear = 0;
    chk("clr_wins_count", int'(count), 0);

    // Start with an empty buffer is ignored.
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 3; i++) begin chk("empty_start_busy", int'(busy), 0); step(); end

    // Start together with a write: write lands, start ignored.
    start = 1;
    do_write(7'h5A);
    start = 0;
    chk("start_wr_count", int'(count), 1);
    chk("start_wr_busy", int'(busy), 0);
    step();
    chk("start_wr_busy2", int'(busy), 0);

    // Abort in WAIT after the first of 3 chars, then replay from char 0.
    do_clear();
    do_write(7'h41); do_write(7'h42); do_write(7'h43);
    plan_fill(3, 1000);
    play(3, 1'b0, 1'b1, 0);
    plan_random(200);
    play(200, 1'b0, 1'b1, 0);
    check_regs("abort");

`ifndef CHAR_SEQ_LOOP_EN
    // ena low for 10 clk in WAIT while ticks keep coming: second strobe slips from rel 5 to rel 15.
    do_clear();
    do_write(7'h61); do_write(7'h62);
    plan_fill(25, 1);
    for (int r = 3; r <= 12; r++) pl_ena[r] = 1'b0;
    base = cyc;
    sq.push_back('{base + 1, 7'h61});
    sq.push_back('{base + 15, 7'h62});
    dq.push_back(base + 19);
    play(25, 1'b0, 1'b0, 19);
`else
    // Looping 2-char message: 0,1,0,1 then abort, no done.
    do_clear();
    do_write(7'h30); do_write(7'h31);
    plan_fill(14, 1);
    base = cyc;
    sq.push_back('{base + 1, 7'h30});
    sq.push_back('{base + 5, 7'h31});
    sq.push_back('{base + 9, 7'h30});
    sq.push_back('{base + 13, 7'h31});
    play(14, 1'b0, 1'b0, 15);
`endif

    // Randomized messages, tick schedules, ena gaps, abort points and ignored-input noise.
    for (int it = 0; it < 12; it++) begin
      do_clear();
      len = $urandom_range(1, 18);
      for (int i = 0; i < len; i++) do_write(7'($urandom_range(0, 127)));
      check_regs("rand_wr");
      plan_random($urandom_range(5, 300));
      begin
        int stop;
        stop = 5;
        for (int s = 300; s >= 5; s--) if (pl_ena[s] && stop == 5) stop = s;
        plan_random(stop);
        play(stop, 1'b1, 1'b1, 0);
      end
      check_regs("rand_play");
    end

    // Reset mid-playback.
    do_clear();
    do_write(7'h7E); do_write(7'h7F);
    base = cyc;
    sq.push_back('{base + 1, 7'h7E});
    start = 1;
    step();
    start = 0;
    repeat (4) step();
    chk("pre_reset_busy", int'(busy), 1);
    rst_n = 0;
    step();
    chk("mid_rst_char_out", int'(char_out), 0);
    chk("mid_rst_char_available", int'(char_available), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_overflow", int'(overflow), 0);
    rst_n = 1;
    repeat (3) step();

    chk("strobes_pending", sq.size(), 0);
    chk("done_pending", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
